serial_add_sched: RTL and testbench
===================================

// Module: serial_add_sched
// PURPOSE
//  Bit-serial N-bit adder controller that time-shares one registered 1-bit full-adder cell
//  (sync_FA: a, b, cin -> sum, cout, registered on clk, 1-cycle latency) between two requesters.
//  A round-robin arbiter grants one requester, and an FSM streams its operands LSB-first through the cell.
//  The FSM feeds each carry back, assembles the W-bit sum, and returns a one-cycle done pulse.
// PARAMETERS
//  W     8   operand/result width in bits (W >= 2)
//  CW    4   bit-counter width, >= clog2(W+1)
// PORTS
//  clk     in   1  system clock, all state on rising edge
//  rst_n   in   1  asynchronous active-low reset
//  req0    in   1  requester 0 request, level; held high until done0
//  a0      in   W  requester 0 operand A, sampled at grant edge only
//  b0      in   W  requester 0 operand B, sampled at grant edge only
//  cin0    in   1  requester 0 carry-in, sampled at grant edge only
//  req1    in   1  requester 1 request (same rules as req0)
//  a1      in   W  requester 1 operand A
//  b1      in   W  requester 1 operand B
//  cin1    in   1  requester 1 carry-in
//  gnt0    out  1  high from grant edge until end of DONE cycle for requester 0
//  gnt1    out  1  same for requester 1
//  done0   out  1  one-cycle pulse: sum_o/cout_o valid for requester 0
//  done1   out  1  one-cycle pulse: sum_o/cout_o valid for requester 1
//  busy    out  1  high in any state other than IDLE
//  sum_o   out  W  result register, holds last result until next DONE
//  cout_o  out  1  final carry-out, holds until next DONE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit_cnt 0; last_gnt = 1 (requester 0 wins first tie).
//    Reset takes effect immediately at any point. An aborted operation produces no done pulse.
//    The cell has no reset; its outputs are ignored outside RUN/DONE capture.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: at edge E0, if req0|req1, pick a winner.
//    Single request wins. Tie goes to requester != last_gnt.
//    Load a/b/cin of winner into shift regs; set gnt, last_gnt, busy; bit_cnt = 0; go to RUN.
//  RUN: during the cycle after E(k), drive cell with a[k], b[k], and cin.
//    cin = loaded cin for k = 0, otherwise cell cout (the carry of bit k-1).
//    Cell registers bit k at E(k+1).
//    At E(k+1), k >= 1: capture cell sum into sum_o[k-1].
//    Stop driving new bits after k = W-1.
//  RUN -> DONE at E(W+1):
//    capture cell sum into sum_o[W-1] and cell cout into cout_o;
//    assert done of granted requester.
//  DONE lasts exactly 1 cycle. At E(W+2): done = 0, gnt = 0, busy = 0; go to IDLE.
//  Latency: done high W+1 cycles after grant edge E0.
//    Next arbitration is no earlier than E(W+3). Period is W+3 cycles under continuous load.
//  Requester contract: drop req in the cycle after done.
//    A req still high at the IDLE edge is a new request.
//  req dropped mid-RUN: ignored. The operation completes and done still pulses.
//  Operand changes after E0: no effect.
//  Arithmetic: {cout_o, sum_o} == a + b + cin, modulo 2^(W+1). No saturation.
//  sum_o bits not yet rewritten during RUN hold stale values. Consumers read only on done.
// TESTING
//  1 W=8, req0 a=8'h35 b=8'h4A cin=0 -> done0 exactly 9 cycles after grant; sum_o=8'h7F, cout_o=0.
//  2 Carry chain: a=8'hFF b=8'h01 cin=0 -> sum 8'h00 cout 1; a=8'hFF b=8'hFF cin=1 -> 8'hFF cout 1.
//  3 req0 and req1 both high out of reset, held after every done -> grant order 0,1,0,1.
//    Each gnt never overlaps the other.
//  4 req1 continuous, req0 raised mid-RUN -> req0 served on the very next arbitration; no starvation.
//  5 rst_n low during RUN at bit 4 -> all outputs 0 that cycle, no done.
//    After release, req0 a=8'h10 b=8'h20 -> 8'h30, cout 0.
//  6 W=4, all 512 (a,b,cin) combos via both requesters -> {cout_o,sum_o} == a+b+cin every time.

Source files
------------

// File: rtl/serial_add_sched.sv
// serial_add_sched: bit-serial W-bit adder shared by two requesters.
// A round-robin arbiter grants one requester. Its operands are then streamed
// LSB-first through a single registered full-adder cell (sync_fa), and the
// carry is fed back each cycle. The assembled sum and carry-out are reported
// with a one-cycle done pulse to the granted requester.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req0/a0/b0/cin0        requester 0 request (level) and operands
//   req1/a1/b1/cin1        requester 1 request (level) and operands
//   gnt0, gnt1             grant, held from grant edge through the DONE cycle
//   done0, done1           one-cycle result-valid pulse
//   busy                   high whenever the controller is not IDLE
//   sum_o, cout_o          result registers, updated at the end of each add

// Registered 1-bit full adder, one cycle latency, no reset.
module sync_fa (
    input  logic clk,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    always_ff @(posedge clk) begin
        sum  <= a ^ b ^ cin;
        cout <= (a & b) | (a & cin) | (b & cin);
    end
endmodule

module serial_add_sched #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         cin0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         cin1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         busy,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic            cin_r;
    logic [CW-1:0]   bit_cnt;
    logic            last_gnt;
    logic            sel;
    logic            pick1_c;
    logic            fa_cin_c;
    logic            fa_sum;
    logic            fa_cout;

    // Single request wins; a tie goes to the requester not served last.
    always_comb begin
        pick1_c = req1 & (~req0 | ~last_gnt);
    end

    // Bit 0 takes the loaded carry-in, later bits take the cell's own carry.
    always_comb begin
        fa_cin_c = (bit_cnt == '0) ? cin_r : fa_cout;
    end

    sync_fa u_fa (
        .clk  (clk),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (fa_cin_c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Arbitration, operand streaming and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            cin_r    <= 1'b0;
            bit_cnt  <= '0;
            last_gnt <= 1'b1;
            sel      <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            sum_o    <= '0;
            cout_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        sel      <= pick1_c;
                        last_gnt <= pick1_c;
                        a_sh     <= pick1_c ? a1 : a0;
                        b_sh     <= pick1_c ? b1 : b0;
                        cin_r    <= pick1_c ? cin1 : cin0;
                        gnt0     <= ~pick1_c;
                        gnt1     <= pick1_c;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    // Cell output now holds bit (bit_cnt-1); store it in place.
                    for (int unsigned i = 0; i < W; i++) begin
                        if (CW'(i + 1) == bit_cnt) begin
                            sum_o[i] <= fa_sum;
                        end
                    end
                    if (bit_cnt == CW'(W)) begin
                        cout_o <= fa_cout;
                        done0  <= ~sel;
                        done1  <= sel;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: an 8-bit instance for latency,
// arbitration and reset scenarios, and a 4-bit instance for exhaustive sums.
module tb_serial_add_sched;
    logic clk;
    logic rst_n;

    // 8-bit instance
    logic       req0, req1, cin0, cin1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy, cout_o;
    logic [7:0] sum_o;

    // 4-bit instance
    logic       qreq0, qreq1, qcin0, qcin1;
    logic [3:0] qa0, qb0, qa1, qb1;
    logic       qgnt0, qgnt1, qdone0, qdone1, qbusy, qcout_o;
    logic [3:0] qsum_o;

    int n_cmp;
    int n_err;

    serial_add_sched #(.W(8), .CW(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .sum_o(sum_o), .cout_o(cout_o)
    );

    serial_add_sched #(.W(4), .CW(3)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(qreq0), .a0(qa0), .b0(qb0), .cin0(qcin0),
        .req1(qreq1), .a1(qa1), .b1(qb1), .cin1(qcin1),
        .gnt0(qgnt0), .gnt1(qgnt1), .done0(qdone0), .done1(qdone1),
        .busy(qbusy), .sum_o(qsum_o), .cout_o(qcout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; qreq0 = 0; qreq1 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one request on the 8-bit instance and check latency and result.
    task automatic run8(input string tag, input bit who, input logic [7:0] a,
                        input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
        int gcyc;
        int dcyc;
        gcyc = -100;
        dcyc = -1;
        @(negedge clk);
        if (who) begin req1 = 1; a1 = a; b1 = b; cin1 = c; end
        else     begin req0 = 1; a0 = a; b0 = b; cin0 = c; end
        for (int cy = 1; cy <= 30; cy++) begin
            @(negedge clk);
            if ((who ? gnt1 : gnt0) && gcyc < 0) gcyc = cy;
            if (who ? done1 : done0) begin
                dcyc = cy;
                break;
            end
        end
        if (who) req1 = 0; else req0 = 0;
        check({tag, " latency"}, 32'(dcyc - gcyc), 32'd9);
        check({tag, " sum"}, 32'(sum_o), 32'(es));
        check({tag, " cout"}, 32'(cout_o), 32'(ec));
    endtask

    // Wait for the next rising grant on the 8-bit instance; -1 on timeout.
    task automatic next_grant(output int who);
        logic p0, p1;
        p0 = gnt0;
        p1 = gnt1;
        who = -1;
        for (int cy = 0; cy < 40; cy++) begin
            @(negedge clk);
            if (gnt0 && !p0) begin who = 0; break; end
            if (gnt1 && !p1) begin who = 1; break; end
            p0 = gnt0;
            p1 = gnt1;
        end
    endtask

    initial begin
        int who;
        int order [4];
        int overlap;
        int ndone;
        bit got;
        logic [3:0] ta, tb;
        logic       tc;
        logic [4:0] tsum;

        n_cmp = 0;
        n_err = 0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; cin0 = 0; cin1 = 0;
        qreq0 = 0; qreq1 = 0; qa0 = 0; qb0 = 0; qa1 = 0; qb1 = 0; qcin0 = 0; qcin1 = 0;
        apply_reset();

        // Reset state
        check("reset outputs", 32'({gnt0, gnt1, done0, done1, busy, cout_o, sum_o}), 32'd0);
        check("reset outputs w4", 32'({qgnt0, qgnt1, qdone0, qdone1, qbusy, qcout_o, qsum_o}), 32'd0);

        // Basic add and carry chains
        run8("t1 35+4a", 1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        run8("t2 ff+01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("t2 ff+ff+1", 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run8("t2 00+00+1", 1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Both requesting from reset: strict alternation, no overlap
        apply_reset();
        a0 = 8'h01; b0 = 8'h02; a1 = 8'h03; b1 = 8'h04; cin0 = 0; cin1 = 0;
        req0 = 1; req1 = 1;
        overlap = 0;
        for (int g = 0; g < 4; g++) begin
            next_grant(who);
            order[g] = who;
            if (gnt0 && gnt1) overlap++;
        end
        for (int cy = 0; cy < 12; cy++) begin
            @(negedge clk);
            if (gnt0 && gnt1) overlap++;
        end
        check("t3 grant #0", 32'(order[0]), 32'd0);
        check("t3 grant #1", 32'(order[1]), 32'd1);
        check("t3 grant #2", 32'(order[2]), 32'd0);
        check("t3 grant #3", 32'(order[3]), 32'd1);
        check("t3 overlap", 32'(overlap), 32'd0);

        // req1 continuous, req0 raised mid-RUN gets the next arbitration
        apply_reset();
        req1 = 1;
        next_grant(who);
        check("t4 first grant", 32'(who), 32'd1);
        repeat (3) @(negedge clk);
        req0 = 1; a0 = 8'h11; b0 = 8'h22; cin0 = 1;
        next_grant(who);
        check("t4 req0 served next", 32'(who), 32'd0);
        got = 0;
        for (int cy = 0; cy < 20; cy++) begin
            if (done0) begin got = 1; break; end
            @(negedge clk);
        end
        req0 = 0;
        check("t4 done0 seen", 32'(got), 32'd1);
        check("t4 req0 sum", 32'({cout_o, sum_o}), 32'h034);
        next_grant(who);
        check("t4 req1 resumes", 32'(who), 32'd1);

        // Reset mid-RUN at bit 4: outputs clear at once, no done afterwards
        apply_reset();
        req0 = 1; a0 = 8'h5A; b0 = 8'h3C; cin0 = 0;
        next_grant(who);
        check("t5 grant", 32'(who), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        check("t5 outputs in reset", 32'({gnt0, gnt1, done0, done1, busy, cout_o, sum_o}), 32'd0);
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        ndone = 0;
        for (int cy = 0; cy < 15; cy++) begin
            @(negedge clk);
            if (done0 || done1 || busy) ndone++;
        end
        check("t5 no done after abort", 32'(ndone), 32'd0);
        run8("t5 10+20", 1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // Exhaustive 4-bit sums, alternating requesters
        for (int i = 0; i < 512; i++) begin
            ta = 4'(i);
            tb = 4'(i >> 4);
            tc = 1'(i >> 8);
            tsum = 5'(ta) + 5'(tb) + 5'(tc);
            @(negedge clk);
            if (i % 2 == 1) begin qreq1 = 1; qa1 = ta; qb1 = tb; qcin1 = tc; end
            else            begin qreq0 = 1; qa0 = ta; qb0 = tb; qcin0 = tc; end
            got = 0;
            for (int cy = 0; cy < 20; cy++) begin
                @(negedge clk);
                if ((i % 2 == 1) ? qdone1 : qdone0) begin got = 1; break; end
            end
            qreq0 = 0;
            qreq1 = 0;
            if (!got) check("t6 done timeout", 32'(got), 32'd1);
            check($sformatf("t6 %0h+%0h+%0h", ta, tb, tc), 32'({qcout_o, qsum_o}), 32'(tsum));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
